parking_ctrl: RTL and testbench

//   Occupancy controller for a single car park with MAX_SPACES bays.

---
 rtl/parking_ctrl.sv | 83 ++++++++
 tb/tb_parking_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl.sv
// Occupancy controller for a single car park: counts cars in and out and
// flags full / space-available from registered state only.
module parking_ctrl #(
   parameter int MAX_SPACES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       entry_pulse,
   input  logic       exit_pulse,
   output logic [5:0] count,
   output logic       full,
   output logic       available
);

   localparam logic [5:0] MaxC = 6'(MAX_SPACES);
   localparam logic [5:0] OneC = 6'd1;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] count_q, count_d;
   logic       entryOnly, exitOnly;

   // Simultaneous entry and exit cancel out, so only lone pulses move the count.
   assign entryOnly = entry_pulse & ~exit_pulse;
   assign exitOnly  = exit_pulse & ~entry_pulse;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         count_q <= 6'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Saturation comes from the state guards: FULL refuses entries, EMPTY ignores exits.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         EMPTY: begin
            if (entryOnly) begin
               count_d = count_q + OneC;
               state_d = (MaxC == OneC) ? FULL : PARTIAL;
            end
         end
         PARTIAL: begin
            if (entryOnly) begin
               count_d = count_q + OneC;
               if (count_q + OneC == MaxC) begin
                  state_d = FULL;
               end
            end else if (exitOnly) begin
               count_d = count_q - OneC;
               if (count_q == OneC) begin
                  state_d = EMPTY;
               end
            end
         end
         FULL: begin
            if (exitOnly) begin
               count_d = count_q - OneC;
               state_d = (MaxC == OneC) ? EMPTY : PARTIAL;
            end
         end
         default: begin
            state_d = EMPTY;
            count_d = 6'd0;
         end
      endcase
   end

   assign count     = count_q;
   assign full      = (state_q == FULL);
   assign available = ~full;

endmodule

// File: tb/tb_parking_ctrl.sv
// Directed self-checking bench for parking_ctrl with MAX_SPACES = 20.
module tb_parking_ctrl;

   logic       clk;
   logic       rst;
   logic       entry_pulse;
   logic       exit_pulse;
   logic [5:0] count;
   logic       full;
   logic       available;

   int vectors;
   int miscompares;

   parking_ctrl #(.MAX_SPACES(20)) dut (
      .clk         (clk),
      .rst         (rst),
      .entry_pulse (entry_pulse),
      .exit_pulse  (exit_pulse),
      .count       (count),
      .full        (full),
      .available   (available)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one clock's worth of pulses, then leaves outputs settled 1ns past the edge.
   task automatic step(input logic e, input logic x);
      @(negedge clk);
      entry_pulse = e;
      exit_pulse  = x;
      @(posedge clk);
      #1;
      entry_pulse = 1'b0;
      exit_pulse  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      entry_pulse = 1'b0;
      exit_pulse  = 1'b0;
      rst         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({count, full, available} !== {6'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL reset_asserted: count=%0d full=%0b avail=%0b, want 0/0/1", count, full, available);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0);
         vectors++;
         if ({count, full, available} !== {6'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_hold[%0d]: count=%0d full=%0b avail=%0b, want 0/0/1", i, count, full, available);
         end
      end
   endtask

   task automatic test_entries_exits();
      logic [5:0] exp;
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 1'b0);
         exp = 6'(i);
         vectors++;
         if ({count, full, available} !== {exp, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL entry[%0d]: count=%0d full=%0b avail=%0b, want %0d/0/1", i, count, full, available, exp);
         end
      end
      for (int i = 1; i <= 2; i++) begin
         step(1'b0, 1'b1);
         exp = 6'(5 - i);
         vectors++;
         if ({count, full, available} !== {exp, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL exit[%0d]: count=%0d full=%0b avail=%0b, want %0d/0/1", i, count, full, available, exp);
         end
      end
   endtask

   task automatic test_fill();
      logic [5:0] exp;
      logic       expFull;
      for (int i = 1; i <= 17; i++) begin
         step(1'b1, 1'b0);
         exp     = 6'(3 + i);
         expFull = (i == 17);
         vectors++;
         if ({count, full, available} !== {exp, expFull, ~expFull}) begin
            miscompares++;
            $display("[TB] FAIL fill[%0d]: count=%0d full=%0b avail=%0b, want %0d/%0b/%0b", i, count, full, available, exp, expFull, ~expFull);
         end
      end
      step(1'b1, 1'b0);
      vectors++;
      if ({count, full, available} !== {6'd20, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL fill_overflow: count=%0d full=%0b avail=%0b, want 20/1/0", count, full, available);
      end
   endtask

   task automatic test_drain();
      logic [5:0] exp;
      for (int i = 1; i <= 22; i++) begin
         step(1'b0, 1'b1);
         exp = (i >= 20) ? 6'd0 : 6'(20 - i);
         vectors++;
         if ({count, full, available} !== {exp, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL drain[%0d]: count=%0d full=%0b avail=%0b, want %0d/0/1", i, count, full, available, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      vectors++;
      if ({count, full, available} !== {6'd5, 1'b0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL both_at_5: count=%0d full=%0b avail=%0b, want 5/0/1", count, full, available);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      vectors++;
      if ({count, full, available} !== {6'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL both_at_0: count=%0d full=%0b avail=%0b, want 0/0/1", count, full, available);
      end
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      vectors++;
      if ({count, full, available} !== {6'd20, 1'b1, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL both_at_20: count=%0d full=%0b avail=%0b, want 20/1/0", count, full, available);
      end
      step(1'b0, 1'b1);
      vectors++;
      if ({count, full, available} !== {6'd19, 1'b0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL exit_from_full: count=%0d full=%0b avail=%0b, want 19/0/1", count, full, available);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
      vectors++;
      if (count !== 6'd12) begin
         miscompares++;
         $display("[TB] FAIL pre_async_count: count=%0d, want 12", count);
      end
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if ({count, full, available} !== {6'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL async_reset: count=%0d full=%0b avail=%0b, want 0/0/1", count, full, available);
      end
      entry_pulse = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (count !== 6'd0) begin
         miscompares++;
         $display("[TB] FAIL pulse_in_reset: count=%0d, want 0", count);
      end
      entry_pulse = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0);
      vectors++;
      if ({count, full, available} !== {6'd1, 1'b0, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL after_async_reset: count=%0d full=%0b avail=%0b, want 1/0/1", count, full, available);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_entries_exits();
      test_fill();
      test_drain();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
